// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and sizing for the uart_rx receiver.
//   rx_state_e     - receiver frame state (IDLE, START, DATA, PARITY, STOP)
//   PRESCALE_DEF   - default maximum oversampling ratio
//   DATA_WIDTH_DEF - default number of data bits per frame
//   EDGE_W         - width of the edge counter / Prescale port at the default ratio
package uart_rx_pkg;

  localparam int PRESCALE_DEF   = 32;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int EDGE_W         = $clog2(PRESCALE_DEF) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: three-tap majority-vote sampler for one serial bit.
// Ports:
//   clk, rst     - receiver clock, asynchronous active-high reset
//   edge_cnt     - position inside the current bit (0..prescale-1)
//   prescale     - clock cycles per serial bit for the current frame
//   rx_in        - serial line
//   sampled_bit  - majority of the three taps around mid-bit
//   sample_done  - high for the one cycle where sampled_bit is first valid
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int EW = EDGE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [EW-1:0] edge_cnt,
  input  logic [EW-1:0] prescale,
  input  logic          rx_in,
  output logic          sampled_bit,
  output logic          sample_done
);

  logic [EW-1:0] half;
  logic [2:0]    tap_q;
  logic [2:0]    tap_d;

  assign half = prescale >> 1;

  // Taps sit at half-1, half and half+1; each holds its value until the
  // same position comes round in the next bit.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tap
      assign tap_d[gi] = (edge_cnt == half + EW'(gi) - EW'(1)) ? rx_in : tap_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_q <= '0;
    end else begin
      tap_q <= tap_d;
    end
  end

  assign sampled_bit = (tap_q[0] & tap_q[1]) | (tap_q[0] & tap_q[2]) | (tap_q[1] & tap_q[2]);
  // Last tap is registered at half+1, so the vote is usable from half+2.
  assign sample_done = (edge_cnt == half + EW'(2));

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Ports:
//   CLK        - oversampling clock (rising edge)
//   RST        - asynchronous active-high reset
//   PAR_TYP    - 0 even parity, 1 odd parity
//   PAR_EN     - frame carries a parity bit
//   Prescale   - CLK cycles per serial bit (8, 16 or 32)
//   RX_IN      - serial line, idle high
//   P_Data     - last correctly received word
//   Data_Valid - one-cycle strobe when P_Data is updated
// Optional (macro UART_RX_ERR_FLAGS_EN):
//   Par_Err, Stp_Err - parity / stop error of the current or last frame
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE   = PRESCALE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      PAR_TYP,
  input  logic                      PAR_EN,
  input  logic [$clog2(PRESCALE):0] Prescale,
  input  logic                      RX_IN,
  output logic [DATA_WIDTH-1:0]     P_Data,
  output logic                      Data_Valid
`ifdef UART_RX_ERR_FLAGS_EN
  ,
  output logic                      Par_Err,
  output logic                      Stp_Err
`endif
);

  localparam int EW = $clog2(PRESCALE) + 1;
  localparam int BW = $clog2(DATA_WIDTH) + 1;

  rx_state_e             state_q, state_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [EW-1:0]         prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  valid_q, valid_d;

  logic last_edge;
  logic enter_start;
  logic sampled_bit;
  logic sample_done;

  uart_rx_sampler #(.EW(EW)) u_sampler (
    .clk         (CLK),
    .rst         (RST),
    .edge_cnt    (edge_q),
    .prescale    (prescale_q),
    .rx_in       (RX_IN),
    .sampled_bit (sampled_bit),
    .sample_done (sample_done)
  );

  assign last_edge = (edge_q == prescale_q - EW'(1));

  always_comb begin
    state_d     = state_q;
    edge_d      = (state_q == IDLE || last_edge) ? '0 : edge_q + EW'(1);
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    prescale_d  = prescale_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    par_err_d   = par_err_q;
    stp_err_d   = stp_err_q;
    p_data_d    = p_data_q;
    valid_d     = 1'b0;
    enter_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (!RX_IN) enter_start = 1'b1;
      end
      START: begin
        // A high mid-bit vote means the falling edge was a glitch.
        if (sample_done && sampled_bit) begin
          state_d = IDLE;
          edge_d  = '0;
        end else if (last_edge) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (sample_done) shreg_d = {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
        if (last_edge) begin
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        // Even: bit equals XOR of data; odd: its complement.
        if (sample_done && (sampled_bit != ((^shreg_q) ^ par_typ_q))) par_err_d = 1'b1;
        if (last_edge) state_d = STOP;
      end
      STOP: begin
        if (sample_done && !sampled_bit) stp_err_d = 1'b1;
        if (last_edge) begin
          if (!par_err_q && !stp_err_q) begin
            p_data_d = shreg_q;
            valid_d  = 1'b1;
          end
          // A low line at the end of stop is the next frame's start bit.
          if (!RX_IN) enter_start = 1'b1;
          else        state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_start) begin
      state_d    = START;
      edge_d     = '0;
      bit_d      = '0;
      prescale_d = Prescale;
      par_en_d   = PAR_EN;
      par_typ_d  = PAR_TYP;
      par_err_d  = 1'b0;
      stp_err_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
      p_data_q   <= p_data_d;
      valid_q    <= valid_d;
    end
  end

  assign P_Data     = p_data_q;
  assign Data_Valid = valid_q;
`ifdef UART_RX_ERR_FLAGS_EN
  assign Par_Err    = par_err_q;
  assign Stp_Err    = stp_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       par_typ;
  logic       par_en;
  logic [5:0] prescale;
  logic       rx_in;
  logic [7:0] p_data;
  logic       data_valid;
`ifdef UART_RX_ERR_FLAGS_EN
  logic       par_err;
  logic       stp_err;
`endif

  uart_rx dut (
    .CLK        (clk),
    .RST        (rst),
    .PAR_TYP    (par_typ),
    .PAR_EN     (par_en),
    .Prescale   (prescale),
    .RX_IN      (rx_in),
    .P_Data     (p_data),
    .Data_Valid (data_valid)
`ifdef UART_RX_ERR_FLAGS_EN
    ,
    .Par_Err    (par_err),
    .Stp_Err    (stp_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         start;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         n_expected = 0;
  int         n_strobes = 0;
  logic [7:0] last_good = 8'h00;
  logic       dv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expected frame, in data and timing.
  always @(negedge clk) begin
    if (rst) begin
      dv_prev <= 1'b0;
    end else begin
      if (data_valid) begin
        n_strobes++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL strobe: unexpected Data_Valid, P_Data=0x%0h, expected none (cycle %0d)", p_data, cyc);
        end else begin
          exp_t e;
          int   dl;
          e  = exp_q.pop_front();
          dl = cyc - e.start - e.lat;
          if (p_data !== e.data || dl < -1 || dl > 1) begin
            failures++;
            $display("FAIL strobe: P_Data=0x%0h latency_off=%0d, expected 0x%0h within +/-1", p_data, dl, e.data);
          end else begin
            $display("ok   strobe: P_Data=0x%0h latency_off=%0d (cycle %0d)", p_data, dl, cyc);
          end
        end
        checks++;
        if (dv_prev) begin
          failures++;
          $display("FAIL dv_width: Data_Valid high two cycles, expected one");
        end
      end
      dv_prev <= data_valid;
    end
  end

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Reference model: parity from the count of ones; a frame is accepted
  // only when its parity (if any) is right and its stop bit is 1.
  task automatic send_frame(input logic [7:0] data, input int ps, input bit pe, input bit pt,
                            input bit bad_par, input bit stop_val);
    bit   par;
    exp_t e;
    par = (($countones(data) % 2) == 1) ? !pt : pt;
    if (bad_par) par = !par;
    prescale = 6'(ps);
    par_en   = pe;
    par_typ  = pt;
    if (!(pe && bad_par) && stop_val) begin
      e.data  = data;
      e.start = cyc;
      e.lat   = ps * (8 + 2 + (pe ? 1 : 0));
      exp_q.push_back(e);
      n_expected++;
      last_good = data;
    end
    rx_in = 1'b0;
    repeat (ps) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = data[i];
      repeat (ps) @(negedge clk);
    end
    if (pe) begin
      rx_in = par;
      repeat (ps) @(negedge clk);
    end
    rx_in = stop_val;
    repeat (ps) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rx_in = 1'b1; par_typ = 1'b0; par_en = 1'b0; prescale = 6'd32;
    repeat (3) @(negedge clk);
    check("reset_pdata", int'(p_data), 0);
    check("reset_dv", int'(data_valid), 0);
    rst = 1'b0;
    idle(5);

    // Plain frame then idle.
    send_frame(8'hA5, 32, 0, 0, 0, 1);
    idle(64);
    check("a5_pdata", int'(p_data), 'hA5);

    // Even parity, back-to-back.
    send_frame(8'h3C, 32, 1, 0, 0, 1);
    send_frame(8'h07, 32, 1, 0, 0, 1);
    idle(64);
    check("b2b_pdata", int'(p_data), 'h07);

    // Wrong parity bit: no strobe, word held.
    send_frame(8'h3C, 32, 1, 0, 1, 1);
    idle(64);
    check("par_err_hold", int'(p_data), 'h07);
`ifdef UART_RX_ERR_FLAGS_EN
    check("par_err_flag", int'(par_err), 1);
`endif

    // Odd parity good, then stop bit low.
    send_frame(8'h55, 32, 1, 1, 0, 1);
    idle(64);
    check("odd_pdata", int'(p_data), 'h55);
    send_frame(8'h55, 32, 1, 1, 0, 0);
    idle(64);
    check("stp_err_hold", int'(p_data), 'h55);
`ifdef UART_RX_ERR_FLAGS_EN
    check("stp_err_flag", int'(stp_err), 1);
`endif

    // One-cycle glitch while idle, then frames at two ratios.
    prescale = 6'd32;
    rx_in = 1'b0;
    @(negedge clk);
    idle(80);
    check("glitch_hold", int'(p_data), 'h55);
    send_frame(8'h81, 8, 0, 0, 0, 1);
    idle(20);
    send_frame(8'h81, 16, 0, 0, 0, 1);
    idle(40);
    check("ps_8_16_pdata", int'(p_data), 'h81);

    // Reset in the middle of the data bits.
    prescale = 6'd32; par_en = 1'b0;
    rx_in = 1'b0;
    repeat (32) @(negedge clk);
    rx_in = 1'b1;
    repeat (80) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pdata", int'(p_data), 0);
    check("midrst_dv", int'(data_valid), 0);
    rst = 1'b0;
    last_good = 8'h00;
    idle(10);
    send_frame(8'hF0, 32, 0, 0, 0, 1);
    idle(64);
    check("after_rst_pdata", int'(p_data), 'hF0);

    // Randomized frames with occasional errors and back-to-back starts.
    for (int n = 0; n < 40; n++) begin
      int r;
      int gap;
      bit pe;
      r   = $urandom_range(0, 9);
      pe  = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 4);
      send_frame(8'($urandom), 8 << $urandom_range(0, 2), pe, 1'($urandom_range(0, 1)),
                 (r == 0), (r != 1));
      if (gap > 0) idle(gap);
    end
    idle(100);
    check("final_pdata", int'(p_data), int'(last_good));
    check("queue_drained", exp_q.size(), 0);
    check("strobe_count", n_strobes, n_expected);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver that oversamples RX_IN with the receiver clock and recovers one frame at a time. Frame format: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit. The block sits behind the pad synchronizer in the UART subsystem. It presents the recovered word on P_Data with a one-cycle Data_Valid strobe for every error-free frame.

Parameters:
PRESCALE, 32, maximum oversampling ratio; sizes the Prescale port and the edge counter; supported runtime ratios are 8, 16, 32 (≤ PRESCALE)
DATA_WIDTH, 8, number of data bits per frame

Ports:
CLK  input  1  receiver oversampling clock, rising-edge
RST  input  1  reset; one clock, asynchronous, active-high
PAR_TYP  input  1  0 = even parity, 1 = odd parity
PAR_EN  input  1  1 = frame carries a parity bit
Prescale  input  $clog2(PRESCALE)+1  CLK cycles per serial bit
RX_IN  input  1  serial line, idle high
P_Data  output  DATA_WIDTH  last correctly received word
Data_Valid  output  1  one-cycle strobe, P_Data holds a new valid word

Behaviour:
- Reset: state IDLE, all counters 0, P_Data = 0, Data_Valid = 0. Reset asserted mid-frame aborts the frame with no strobe.
- Edge counter: counts 0..Prescale-1 within each bit; wraps to 0 and increments the bit counter.
- Sampler: captures RX_IN at edge counts Prescale/2-1, Prescale/2 and Prescale/2+1. Sampled bit = majority of the three, valid from edge count Prescale/2+2.
- Prescale, PAR_EN and PAR_TYP are latched on leaving IDLE and held constant for the rest of the frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: RX_IN = 0 -> START, edge counter = 0.
- START: sampled bit = 1 is a glitch -> IDLE with no strobe and no error. Otherwise, at the end of the bit -> DATA.
- DATA: each sampled bit is shifted into the shift register LSB first. After DATA_WIDTH bits -> PARITY if PAR_EN, else STOP.
- PARITY: expected bit = XOR of data for even, XNOR of data for odd. Mismatch sets the internal par_err. End of bit -> STOP.
- STOP: sampled bit = 0 sets the internal stp_err.
- STOP end of bit, no errors: P_Data <= shift register and Data_Valid = 1 for exactly one CLK.
- STOP end of bit, any error: no strobe and P_Data keeps its previous value.
- Exit from STOP: RX_IN = 0 at that edge -> START directly (back-to-back frames, no idle bit). Otherwise -> IDLE.
- Error flags clear on entry to START.
- Latency: Data_Valid rises Prescale·(DATA_WIDTH+2+PAR_EN) CLK cycles after the start falling edge, ±1 cycle.
- Data_Valid is never high for two consecutive cycles.

Optional Feature:
Macro UART_RX_ERR_FLAGS_EN.
- Defined: adds output ports Par_Err and Stp_Err (1 bit each, reset 0). Each mirrors its internal error flag, is set when its error is detected, holds through the end of the frame, and clears on entry to START.
- Undefined: no such ports. Errors only suppress Data_Valid.

Decomposition:
- Package uart_rx_pkg holds the state enum (IDLE, START, DATA, PARITY, STOP) and the localparam EDGE_W = $clog2(PRESCALE)+1.
- One natural sub-module: uart_rx_sampler. It takes edge count, Prescale and RX_IN and returns the majority-voted sampled bit and a sample_done flag.
- FSM, counters, deserializer and checkers stay in uart_rx.

Test Plan:
- Prescale=32, PAR_EN=0, frame 0xA5 followed by idle -> Data_Valid pulse once, P_Data=0xA5, state returns to IDLE.
- Even parity, data 0x3C, parity bit 0, sent back-to-back into a second frame 0x07 with parity bit 1 -> two strobes, P_Data=0x3C then 0x07, no IDLE between frames.
- Even parity, data 0x3C, parity bit 1 -> no strobe, P_Data keeps its previous value; with UART_RX_ERR_FLAGS_EN, Par_Err=1.
- Odd parity, data 0x55 with parity bit 1 (correct) -> strobe, P_Data=0x55. Same data with stop bit 0 -> no strobe, Stp_Err=1.
- RX_IN low for a single CLK cycle while idle -> START aborts to IDLE, no strobe. A following valid frame 0x81 at Prescale=8 and Prescale=16 -> P_Data=0x81 with one strobe each.
- RST asserted in the middle of the DATA state -> P_Data=0, Data_Valid=0, IDLE. A subsequent frame 0xF0 is received correctly.
